// File: rtl/inst_loader.sv
// Program loader: packs UART bytes big-endian into instruction words and writes
// them to consecutive instruction-memory addresses until the HALT word is written.
`ifndef ADDRWIDTH
`define ADDRWIDTH 10
`endif

module inst_loader #(
    parameter int unsigned          NB_DATA   = 32,
    parameter int unsigned          N_BITS    = 8,
    parameter int unsigned          NB_ADDR   = `ADDRWIDTH,
    parameter logic [NB_DATA-1:0]   HALT_WORD = {NB_DATA{1'b1}}
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 rx_done_i,
    input  logic [N_BITS-1:0]    rx_data_i,
    output logic                 en_write_o,
    output logic [NB_ADDR-1:0]   wr_addr_o,
    output logic [NB_DATA-1:0]   inst_load_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [NB_ADDR:0]     word_count_o
);

    localparam int unsigned NB_IDX = 2;
    localparam int unsigned NB_CNT = NB_ADDR + 1;
    localparam logic [NB_IDX-1:0]  IDX_LAST  = '1;
    localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t               r_state, w_state;
    logic [NB_IDX-1:0]    r_idx, w_idx;
    logic [NB_DATA-1:0]   r_shift, w_shift;
    logic [NB_ADDR-1:0]   r_addr, w_addr;
    logic [NB_CNT-1:0]    r_count, w_count;
    logic                 r_en_write, w_en_write;
    logic [NB_ADDR-1:0]   r_wr_addr, w_wr_addr;
    logic [NB_DATA-1:0]   r_inst, w_inst;
    logic                 r_busy, w_busy;
    logic                 r_done, w_done;
    logic                 r_error, w_error;
    logic [NB_DATA-1:0]   w_shifted;

    // Newest byte enters at the bottom, so after four bytes the first sits at the top.
    assign w_shifted = {r_shift[NB_DATA-N_BITS-1:0], rx_data_i};

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_en_write <= 1'b0;
            r_wr_addr  <= '0;
            r_inst     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_shift    <= w_shift;
            r_addr     <= w_addr;
            r_count    <= w_count;
            r_en_write <= w_en_write;
            r_wr_addr  <= w_wr_addr;
            r_inst     <= w_inst;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_shift    = r_shift;
        w_addr     = r_addr;
        w_count    = r_count;
        w_en_write = 1'b0;
        w_wr_addr  = r_wr_addr;
        w_inst     = r_inst;
        w_done     = r_done;
        w_error    = r_error;

        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    w_state = RECV;
                    w_idx   = '0;
                    w_addr  = '0;
                    w_count = '0;
                    w_done  = 1'b0;
                    w_error = 1'b0;
                end
            end
            RECV: begin
                if (rx_done_i) begin
                    w_shift = w_shifted;
                    if (r_idx == IDX_LAST) begin
                        w_state    = WRITE;
                        w_idx      = '0;
                        w_en_write = 1'b1;
                        w_wr_addr  = r_addr;
                        w_inst     = w_shifted;
                    end else begin
                        w_idx = r_idx + NB_IDX'(1);
                    end
                end
            end
            WRITE: begin
                w_count = r_count + NB_CNT'(1);
                // A byte landing in the write cycle starts the next word.
                if (rx_done_i) begin
                    w_shift = w_shifted;
                    w_idx   = NB_IDX'(1);
                end
                if (r_inst == HALT_WORD) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                end else if (r_addr == ADDR_LAST) begin
                    w_state = ERROR;
                    w_error = 1'b1;
                end else begin
                    w_state = RECV;
                    w_addr  = r_addr + NB_ADDR'(1);
                end
            end
            default: w_state = IDLE;
        endcase

        w_busy = (w_state == RECV) || (w_state == WRITE);
    end

    assign en_write_o   = r_en_write;
    assign wr_addr_o    = r_wr_addr;
    assign inst_load_o  = r_inst;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign word_count_o = r_count;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader, built with a 4-word memory
// (NB_ADDR=2) so the memory-full path is reachable.
`timescale 1ns/1ps

module tb_inst_loader;

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned N_BITS  = 8;
    localparam int unsigned NB_ADDR = 2;

    logic                clock_i;
    logic                reset_i;
    logic                start_i;
    logic                rx_done_i;
    logic [N_BITS-1:0]   rx_data_i;
    logic                en_write_o;
    logic [NB_ADDR-1:0]  wr_addr_o;
    logic [NB_DATA-1:0]  inst_load_o;
    logic                busy_o;
    logic                done_o;
    logic                error_o;
    logic [NB_ADDR:0]    word_count_o;

    int checks = 0;
    int errors = 0;

    logic [NB_ADDR-1:0] wa[$];
    logic [NB_DATA-1:0] wd[$];

    inst_loader #(
        .NB_DATA  (NB_DATA),
        .N_BITS   (N_BITS),
        .NB_ADDR  (NB_ADDR),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .rx_done_i   (rx_done_i),
        .rx_data_i   (rx_data_i),
        .en_write_o  (en_write_o),
        .wr_addr_o   (wr_addr_o),
        .inst_load_o (inst_load_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .word_count_o(word_count_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Log every memory write seen on the bus.
    always @(negedge clock_i) begin
        if (en_write_o) begin
            wa.push_back(wr_addr_o);
            wd.push_back(inst_load_o);
        end
    end

    // Drivers all start and end just after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clock_i);
        #1 start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(posedge clock_i);
        #1 rx_done_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (en_write_o !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", en_write_o); end
        checks++; if (wr_addr_o !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", wr_addr_o); end
        checks++; if (inst_load_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst_load_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error_o); end
        checks++; if (word_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", word_count_o); end
    endtask

    task automatic test_basic_load();
        clear_log();
        pulse_start();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got %b want 1", busy_o); end
        send_word(32'h2001_0005);
        idle(1);
        send_word(32'h8C22_0004);
        idle(1);
        send_word(32'hFFFF_FFFF);
        // write cycle is the one right after the 4th byte
        checks++; if (en_write_o !== 1'b1 || wr_addr_o !== 2'd2 || inst_load_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL basic_halt_write got en=%b addr=%0d data=%h want en=1 addr=2 data=ffffffff", en_write_o, wr_addr_o, inst_load_o);
        end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_early got %b want 0", done_o); end
        idle(1);
        checks++; if (en_write_o !== 1'b0) begin errors++; $display("FAIL basic_en_one_cycle got %b want 0", en_write_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done_o); end
        idle(2);
        checks++; if (wa.size() !== 3) begin errors++; $display("FAIL basic_nwrites got %0d want 3", wa.size()); end
        else begin
            checks++; if (wa[0] !== 2'd0 || wd[0] !== 32'h2001_0005) begin errors++; $display("FAIL basic_w0 got %0d/%h want 0/20010005", wa[0], wd[0]); end
            checks++; if (wa[1] !== 2'd1 || wd[1] !== 32'h8C22_0004) begin errors++; $display("FAIL basic_w1 got %0d/%h want 1/8c220004", wa[1], wd[1]); end
            checks++; if (wa[2] !== 2'd2 || wd[2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_w2 got %0d/%h want 2/ffffffff", wa[2], wd[2]); end
        end
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL basic_flags got d=%b b=%b e=%b want d=1 b=0 e=0", done_o, busy_o, error_o); end
        checks++; if (word_count_o !== 3'd3) begin errors++; $display("FAIL basic_count got %0d want 3", word_count_o); end
        checks++; if (wr_addr_o !== 2'd2 || inst_load_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_hold got %0d/%h want 2/ffffffff", wr_addr_o, inst_load_o); end
    endtask

    task automatic test_prestart_ignored();
        do_reset();
        clear_log();
        send_word(32'h1122_3344);
        idle(2);
        checks++; if (wa.size() !== 0 || busy_o !== 1'b0) begin errors++; $display("FAIL pre_no_write got n=%0d busy=%b want 0/0", wa.size(), busy_o); end
        // start and a byte in the same idle cycle: byte must be dropped
        rx_data_i = 8'h99;
        rx_done_i = 1'b1;
        pulse_start();
        rx_done_i = 1'b0;
        send_word(32'h0102_0304);
        idle(1);
        send_word(32'hFFFF_FFFF);
        idle(3);
        checks++; if (wa.size() !== 2) begin errors++; $display("FAIL pre_nwrites got %0d want 2", wa.size()); end
        else begin
            checks++; if (wa[0] !== 2'd0 || wd[0] !== 32'h0102_0304) begin errors++; $display("FAIL pre_w0 got %0d/%h want 0/01020304", wa[0], wd[0]); end
        end
        checks++; if (done_o !== 1'b1 || word_count_o !== 3'd2) begin errors++; $display("FAIL pre_done got d=%b n=%0d want 1/2", done_o, word_count_o); end
    endtask

    task automatic test_memory_full();
        clear_log();
        pulse_start();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL full_done_cleared got %b want 0", done_o); end
        send_word(32'hA000_0000);
        idle(1);
        send_word(32'hA000_0001);
        idle(1);
        send_word(32'hA000_0002);
        idle(1);
        send_word(32'hA000_0003);
        idle(1);
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL full_error_timing got %b want 1", error_o); end
        send_word(32'hA000_0004);
        idle(3);
        checks++; if (wa.size() !== 4) begin errors++; $display("FAIL full_nwrites got %0d want 4", wa.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[i] !== 2'(i) || wd[i] !== (32'hA000_0000 + 32'(i))) begin
                    errors++; $display("FAIL full_w%0d got %0d/%h want %0d/%h", i, wa[i], wd[i], i, 32'hA000_0000 + 32'(i));
                end
            end
        end
        checks++; if (error_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL full_flags got e=%b d=%b b=%b want 1/0/0", error_o, done_o, busy_o); end
        checks++; if (word_count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", word_count_o); end
    endtask

    task automatic test_reset_mid_word();
        clear_log();
        pulse_start();
        checks++; if (error_o !== 1'b0 || word_count_o !== 3'd0) begin errors++; $display("FAIL rmid_start_clear got e=%b n=%0d want 0/0", error_o, word_count_o); end
        send_byte(8'h12);
        send_byte(8'h34);
        do_reset();
        checks++; if (busy_o !== 1'b0 || en_write_o !== 1'b0 || word_count_o !== 3'd0) begin errors++; $display("FAIL rmid_reset got b=%b en=%b n=%0d want 0/0/0", busy_o, en_write_o, word_count_o); end
        checks++; if (wr_addr_o !== 2'd0 || inst_load_o !== 32'h0) begin errors++; $display("FAIL rmid_reset_bus got %0d/%h want 0/0", wr_addr_o, inst_load_o); end
        pulse_start();
        send_word(32'hFFFF_FFFF);
        idle(3);
        checks++; if (wa.size() !== 1) begin errors++; $display("FAIL rmid_nwrites got %0d want 1", wa.size()); end
        else begin
            checks++; if (wa[0] !== 2'd0 || wd[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rmid_w0 got %0d/%h want 0/ffffffff", wa[0], wd[0]); end
        end
        checks++; if (done_o !== 1'b1 || word_count_o !== 3'd1) begin errors++; $display("FAIL rmid_done got d=%b n=%0d want 1/1", done_o, word_count_o); end
    endtask

    task automatic test_start_mid_word();
        clear_log();
        pulse_start();
        send_word(32'h1234_5678);
        idle(1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_start();
        send_byte(8'hCC);
        send_byte(8'hDD);
        idle(3);
        checks++; if (wa.size() !== 2) begin errors++; $display("FAIL smid_nwrites got %0d want 2", wa.size()); end
        else begin
            checks++; if (wa[1] !== 2'd1 || wd[1] !== 32'hAABB_CCDD) begin errors++; $display("FAIL smid_w1 got %0d/%h want 1/aabbccdd", wa[1], wd[1]); end
        end
        checks++; if (busy_o !== 1'b1 || word_count_o !== 3'd2) begin errors++; $display("FAIL smid_state got b=%b n=%0d want 1/2", busy_o, word_count_o); end
        send_word(32'hFFFF_FFFF);
        idle(3);
        checks++; if (done_o !== 1'b1 || word_count_o !== 3'd3) begin errors++; $display("FAIL smid_done got d=%b n=%0d want 1/3", done_o, word_count_o); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        pulse_start();
        send_word(32'h1111_1111);
        // this byte lands in the write cycle
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        send_byte(8'h01);
        checks++; if (en_write_o !== 1'b1 || wr_addr_o !== 2'd1 || inst_load_o !== 32'hABCD_EF01) begin
            errors++; $display("FAIL b2b_write got en=%b addr=%0d data=%h want en=1 addr=1 data=abcdef01", en_write_o, wr_addr_o, inst_load_o);
        end
        idle(1);
        send_word(32'hFFFF_FFFF);
        idle(3);
        checks++; if (wa.size() !== 3) begin errors++; $display("FAIL b2b_nwrites got %0d want 3", wa.size()); end
        else begin
            checks++; if (wd[0] !== 32'h1111_1111 || wa[2] !== 2'd2 || wd[2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_words got %h,%0d/%h want 11111111,2/ffffffff", wd[0], wa[2], wd[2]); end
        end
        checks++; if (done_o !== 1'b1 || word_count_o !== 3'd3) begin errors++; $display("FAIL b2b_done got d=%b n=%0d want 1/3", done_o, word_count_o); end
    endtask

    initial begin
        reset_i   = 1'b1;
        start_i   = 1'b0;
        rx_done_i = 1'b0;
        rx_data_i = '0;
        idle(2);
        test_reset();
        test_basic_load();
        test_prestart_ignored();
        test_memory_full();
        test_reset_mid_word();
        test_start_mid_word();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that sits directly upstream of the instruction memory. It assembles bytes received from the UART receiver into 32-bit instruction words and writes them to consecutive instruction-memory addresses. A load starts on a command pulse from the debug unit and ends when the HALT word has been written. The block drives the memory's write-enable, address and data inputs directly.

## Interface
- NB_DATA, 32: instruction width; must equal 4*N_BITS.
- N_BITS, 8: UART byte width.
- NB_ADDR, `ADDRWIDTH: instruction-memory word-address width.
- HALT_WORD, 32'hFFFF_FFFF: terminating instruction.

- clock_i  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle load command from the debug unit.
- rx_done_i  in  1  one-cycle strobe; rx_data_i is valid in this cycle.
- rx_data_i  in  N_BITS  received byte.
- en_write_o  out  1  memory write enable; one-cycle pulse per word.
- wr_addr_o  out  NB_ADDR  memory word address.
- inst_load_o  out  NB_DATA  instruction word to write.
- busy_o  out  1  high while a load is in progress.
- done_o  out  1  load finished with HALT; holds until the next start or reset.
- error_o  out  1  memory filled without HALT; holds until the next start or reset.
- word_count_o  out  NB_ADDR+1  number of words written in the current or last load.

## Operation
- States:
  - IDLE: waiting for a start command.
  - RECV: collecting bytes of the current word.
  - WRITE: issuing the memory write.
  - DONE: load completed with HALT.
  - ERROR: memory filled without HALT.
- IDLE, DONE or ERROR with start_i=1 → RECV, with these actions:
  - address = 0, byte index = 0, word_count = 0;
  - done_o and error_o are cleared.
- start_i is ignored in RECV and WRITE.
- Byte assembly in RECV:
  - Each rx_done_i captures one byte. Byte order is big-endian: the first byte lands in [31:24] and the fourth in [7:0].
  - When the 4th byte is captured, the next state is WRITE.
- WRITE lasts exactly one cycle:
  - en_write_o=1, wr_addr_o=current address, inst_load_o=assembled word.
  - word_count increments.
  - If the word equals HALT_WORD, the next state is DONE. The HALT word itself is written.
  - Otherwise, if the address equals 2^NB_ADDR-1, the next state is ERROR.
  - Otherwise the address increments by 1 and the next state is RECV.
- An rx_done_i that arrives during WRITE is captured as byte 0 of the next word, and the byte index becomes 1. It is not lost. If WRITE exits to DONE or ERROR, that byte is discarded.
- rx_done_i is ignored in IDLE, DONE and ERROR.
- busy_o = (state is RECV or WRITE).
- wr_addr_o and inst_load_o are registered and hold their last values outside WRITE.
- en_write_o is 0 in every state except WRITE.

## Timing
- Reset values: state IDLE, en_write_o=0, wr_addr_o=0, inst_load_o=0, busy_o=0, done_o=0, error_o=0, word_count_o=0, byte index 0.
- start_i at cycle T → busy_o=1 at T+1.
- 4th rx_done_i at cycle T → en_write_o=1 at T+1 only, with address and data valid in that same cycle.
- done_o or error_o rises at T+2, where T is the cycle of the 4th rx_done_i of the final word.
- Reset during any state, including WRITE, takes effect on the next edge:
  - a partial word is discarded;
  - no further write pulse is issued;
  - all outputs return to their reset values.
- start_i and rx_done_i asserted in the same cycle while in IDLE: the start is taken and the byte is ignored.

## Test plan
- Start, then bytes 20 01 00 05 | 8C 22 00 04 | FF FF FF FF → writes (0, 0x20010005), (1, 0x8C220004), (2, 0xFFFFFFFF). done_o=1, word_count_o=3, busy_o=0.
- Bytes 11 22 33 44 sent before start, then start, then a normal load → the pre-start bytes are ignored and the first write is the word assembled after start.
- NB_ADDR=2, four non-HALT words → four writes at addresses 0..3, then error_o=1, done_o=0, word_count_o=4, no fifth write.
- Reset asserted after 2 bytes, then start and HALT bytes → a single write of 0xFFFFFFFF at address 0; the partial word never appears.
- start_i pulsed mid-word (after byte 2) → no effect; the word completes normally and the address does not reset.
- rx_done_i asserted in the WRITE cycle with byte AB, followed by CD EF 01 → the next write is 0xABCDEF01 at the next address.
